// File: rtl/cc_alu_pkg.sv
// Shared constants, opcode map and FSM encoding for the iterative ALU.
// Widths are also consumed by the PSR and register file.
package cc_alu_pkg;

    localparam int CC_BUS_W   = 32;
    localparam int CC_SEL_W   = 4;
    localparam int CC_SHAMT_W = 5;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_ANDN  = 4'b0101;
    localparam logic [3:0] OP_SLL   = 4'b0110;
    localparam logic [3:0] OP_SRL   = 4'b0111;
    localparam logic [3:0] OP_SRA   = 4'b1000;
    localparam logic [3:0] OP_PASSA = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/cc_alu_flag_gen.sv
// Combinational V/C/N/Z generation from opcode, operands and raw result.
// cx_i carries the adder carry, subtract borrow or last shifted-out bit.
module cc_alu_flag_gen
    import cc_alu_pkg::*;
#(
    parameter int W = CC_BUS_W
) (
    input  logic [3:0]   op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] res_i,
    input  logic         cx_i,
    output logic         v_o,
    output logic         c_o,
    output logic         n_o,
    output logic         z_o
);

    always_comb begin
        v_o = 1'b0;
        c_o = 1'b0;
        n_o = res_i[W-1];
        z_o = (res_i == '0);
        case (op_i)
            OP_ADD: begin
                c_o = cx_i;
                v_o = (a_i[W-1] == b_i[W-1]) && (res_i[W-1] != a_i[W-1]);
            end
            OP_SUB: begin
                c_o = cx_i;
                v_o = (a_i[W-1] != b_i[W-1]) && (res_i[W-1] != a_i[W-1]);
            end
            OP_SLL, OP_SRL, OP_SRA: c_o = cx_i;
            default: ;
        endcase
    end

endmodule

// File: rtl/cc_iterative_alu.sv
// Multi-cycle ALU feeding the PSR: single-cycle arithmetic/logic,
// bit-serial shifts, registered result/flags and a Set_Conditions strobe.
module cc_iterative_alu
    import cc_alu_pkg::*;
#(
    parameter int DATAWIDTH_BUS           = CC_BUS_W,
    parameter int DATAWIDTH_ALU_SELECTION = CC_SEL_W,
    parameter int DATAWIDTH_SHAMT         = CC_SHAMT_W
) (
    input  logic                               CC_ALU_CLOCK_50,
    input  logic                               CC_ALU_RESET_InLow,
    input  logic                               CC_ALU_START,
    input  logic [DATAWIDTH_ALU_SELECTION-1:0] CC_ALU_SELECTION,
    input  logic                               CC_ALU_SETCC,
    input  logic [DATAWIDTH_BUS-1:0]           CC_ALU_DATA_A,
    input  logic [DATAWIDTH_BUS-1:0]           CC_ALU_DATA_B,
    output logic [DATAWIDTH_BUS-1:0]           CC_ALU_DATA_OUT,
    output logic                               CC_ALU_BUSY,
    output logic                               CC_ALU_DONE,
    output logic                               CC_ALU_Set_Conditions,
    output logic                               CC_ALU_overflow,
    output logic                               CC_ALU_carry,
    output logic                               CC_ALU_negative,
    output logic                               CC_ALU_zero
);

    localparam int W = DATAWIDTH_BUS;
    localparam int S = DATAWIDTH_SHAMT;
    localparam int O = DATAWIDTH_ALU_SELECTION;

    state_t         state_q, state_d;
    logic [W-1:0]   work_q, work_d;
    logic [W-1:0]   res_q, res_d;
    logic [S-1:0]   cnt_q, cnt_d;
    logic [O-1:0]   op_q, op_d;
    logic           setcc_q, setcc_d;
    logic           v_q, c_q, n_q, z_q;
    logic           v_d, c_d, n_d, z_d;

    logic [W:0]     sum;
    logic [W-1:0]   alu_r, sh_r, fg_res, fg_a;
    logic           alu_cx, sh_out, fg_cx;
    logic [O-1:0]   fg_op;
    logic           fv, fc, fn, fz;
    logic [S-1:0]   shamt;
    logic           idle;

    assign idle  = (state_q == ST_IDLE);
    assign shamt = CC_ALU_DATA_B[S-1:0];

    always_comb begin
        sum    = {1'b0, CC_ALU_DATA_A} + {1'b0, CC_ALU_DATA_B};
        alu_r  = '0;
        alu_cx = 1'b0;
        case (CC_ALU_SELECTION)
            OP_ADD: begin
                alu_r  = sum[W-1:0];
                alu_cx = sum[W];
            end
            OP_SUB: begin
                alu_r  = CC_ALU_DATA_A - CC_ALU_DATA_B;
                alu_cx = CC_ALU_DATA_A < CC_ALU_DATA_B;
            end
            OP_AND:  alu_r = CC_ALU_DATA_A & CC_ALU_DATA_B;
            OP_OR:   alu_r = CC_ALU_DATA_A | CC_ALU_DATA_B;
            OP_XOR:  alu_r = CC_ALU_DATA_A ^ CC_ALU_DATA_B;
            OP_ANDN: alu_r = CC_ALU_DATA_A & ~CC_ALU_DATA_B;
            OP_SLL, OP_SRL, OP_SRA, OP_PASSA: alu_r = CC_ALU_DATA_A;
            default: ;
        endcase
    end

    // One bit position per clock; sh_out is the bit leaving the word.
    always_comb begin
        sh_r   = work_q;
        sh_out = 1'b0;
        case (op_q)
            OP_SLL: {sh_out, sh_r} = {work_q, 1'b0};
            OP_SRL: {sh_r, sh_out} = {1'b0, work_q};
            OP_SRA: {sh_r, sh_out} = {work_q[W-1], work_q};
            default: ;
        endcase
    end

    assign fg_op  = idle ? CC_ALU_SELECTION : op_q;
    assign fg_a   = idle ? CC_ALU_DATA_A : work_q;
    assign fg_res = idle ? alu_r : sh_r;
    assign fg_cx  = idle ? alu_cx : sh_out;

    cc_alu_flag_gen #(.W(W)) u_flag_gen (
        .op_i  (fg_op),
        .a_i   (fg_a),
        .b_i   (CC_ALU_DATA_B),
        .res_i (fg_res),
        .cx_i  (fg_cx),
        .v_o   (fv),
        .c_o   (fc),
        .n_o   (fn),
        .z_o   (fz)
    );

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        setcc_d = setcc_q;
        res_d   = res_q;
        v_d     = v_q;
        c_d     = c_q;
        n_d     = n_q;
        z_d     = z_q;
        case (state_q)
            ST_IDLE: begin
                if (CC_ALU_START) begin
                    op_d    = CC_ALU_SELECTION;
                    setcc_d = CC_ALU_SETCC;
                    if (is_shift(CC_ALU_SELECTION) && shamt != '0) begin
                        work_d  = CC_ALU_DATA_A;
                        cnt_d   = shamt;
                        state_d = ST_SHIFT;
                    end else begin
                        res_d   = alu_r;
                        {v_d, c_d, n_d, z_d} = {fv, fc, fn, fz};
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                work_d = sh_r;
                cnt_d  = cnt_q - S'(1);
                if (cnt_d == '0) begin
                    res_d   = sh_r;
                    {v_d, c_d, n_d, z_d} = {fv, fc, fn, fz};
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CC_ALU_CLOCK_50 or negedge CC_ALU_RESET_InLow) begin
        if (!CC_ALU_RESET_InLow) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            setcc_q <= 1'b0;
            res_q   <= '0;
            v_q     <= 1'b0;
            c_q     <= 1'b0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            setcc_q <= setcc_d;
            res_q   <= res_d;
            v_q     <= v_d;
            c_q     <= c_d;
            n_q     <= n_d;
            z_q     <= z_d;
        end
    end

    assign CC_ALU_DATA_OUT       = res_q;
    assign CC_ALU_BUSY           = !idle;
    assign CC_ALU_DONE           = (state_q == ST_DONE);
    assign CC_ALU_Set_Conditions = CC_ALU_DONE & setcc_q;
    assign CC_ALU_overflow       = v_q;
    assign CC_ALU_carry          = c_q;
    assign CC_ALU_negative       = n_q;
    assign CC_ALU_zero           = z_q;

endmodule

// File: tb/tb_cc_iterative_alu.sv
// Randomised self-checking bench for cc_iterative_alu against an
// arithmetic reference model of results, flags and latency.
module tb_cc_iterative_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        setcc = 1'b0;
    logic [3:0]  sel = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [31:0] dout;
    logic        busy, done, sc, ov, cy, ng, zr;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    cc_iterative_alu dut (
        .CC_ALU_CLOCK_50       (clk),
        .CC_ALU_RESET_InLow    (rst_n),
        .CC_ALU_START          (start),
        .CC_ALU_SELECTION      (sel),
        .CC_ALU_SETCC          (setcc),
        .CC_ALU_DATA_A         (a),
        .CC_ALU_DATA_B         (b),
        .CC_ALU_DATA_OUT       (dout),
        .CC_ALU_BUSY           (busy),
        .CC_ALU_DONE           (done),
        .CC_ALU_Set_Conditions (sc),
        .CC_ALU_overflow       (ov),
        .CC_ALU_carry          (cy),
        .CC_ALU_negative       (ng),
        .CC_ALU_zero           (zr)
    );

    // Reference: returns result and {V,C,N,Z}.
    function automatic void model(input logic [3:0] op, input logic [31:0] ma,
                                  input logic [31:0] mb, output logic [31:0] r,
                                  output logic [3:0] f);
        int sh;
        longint s;
        logic v, c;
        sh = int'(mb[4:0]);
        v = 1'b0;
        c = 1'b0;
        r = 32'd0;
        case (op)
            4'd0: begin
                s = longint'($signed(ma)) + longint'($signed(mb));
                r = ma + mb;
                c = (64'(ma) + 64'(mb)) > 64'hFFFF_FFFF;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd1: begin
                s = longint'($signed(ma)) - longint'($signed(mb));
                r = ma - mb;
                c = ma < mb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2: r = ma & mb;
            4'd3: r = ma | mb;
            4'd4: r = ma ^ mb;
            4'd5: r = ma & ~mb;
            4'd6: begin
                r = ma << sh;
                c = (sh > 0) ? ma[32-sh] : 1'b0;
            end
            4'd7: begin
                r = ma >> sh;
                c = (sh > 0) ? ma[sh-1] : 1'b0;
            end
            4'd8: begin
                r = $unsigned($signed(ma) >>> sh);
                c = (sh > 0) ? ma[sh-1] : 1'b0;
            end
            4'd9: r = ma;
            default: r = 32'd0;
        endcase
        f = {v, c, r[31], r == 32'd0};
    endfunction

    function automatic int exp_lat(input logic [3:0] op, input logic [31:0] mb);
        if ((op == 4'd6 || op == 4'd7 || op == 4'd8) && mb[4:0] != 5'd0)
            return 1 + int'(mb[4:0]);
        return 1;
    endfunction

    // Drives one op from IDLE and returns what was seen at DONE and one cycle later.
    task automatic run_op(input logic [3:0] op, input logic [31:0] ia, input logic [31:0] ib,
                          input logic isc, input bit toggle, input bit hold,
                          output int lat, output logic [31:0] od, output logic [3:0] of,
                          output logic osc, output logic obusy, output logic done_after,
                          output logic busy_after, output logic sc_after);
        sel = op;
        a = ia;
        b = ib;
        setcc = isc;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            if (toggle) begin
                a = $urandom;
                b = $urandom;
                sel = 4'($urandom_range(0, 15));
                setcc = 1'($urandom_range(0, 1));
                start = 1'($urandom_range(0, 1));
            end
        end
        od = dout;
        of = {ov, cy, ng, zr};
        osc = sc;
        obusy = busy;
        start = hold;
        if (hold) begin
            sel = 4'd0;
            a = 32'd1;
            b = 32'd1;
        end
        @(negedge clk);
        done_after = done;
        busy_after = busy;
        sc_after = sc;
        start = 1'b0;
    endtask

    int          lat;
    logic [31:0] od, er;
    logic [3:0]  of, ef;
    logic        osc, obusy, da, ba, sa;

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (dout !== 32'd0) begin bad++; $display("FAIL reset_dout got=%h exp=0", dout); end
        total++;
        if ({busy, done, sc, ov, cy, ng, zr} !== 7'd0) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=0", {busy, done, sc, ov, cy, ng, zr});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add_ovf;
        run_op(4'd0, 32'h7FFF_FFFF, 32'h1, 1'b1, 1'b0, 1'b0, lat, od, of, osc, obusy, da, ba, sa);
        total++;
        if (lat !== 1) begin bad++; $display("FAIL add_lat got=%0d exp=1", lat); end
        total++;
        if (od !== 32'h8000_0000) begin bad++; $display("FAIL add_dout got=%h exp=80000000", od); end
        total++;
        if (of !== 4'b1010) begin bad++; $display("FAIL add_flags got=%b exp=1010", of); end
        total++;
        if ({osc, da, sa} !== 3'b100) begin bad++; $display("FAIL add_pulse got=%b exp=100", {osc, da, sa}); end
    endtask

    task automatic test_sub_zero;
        run_op(4'd1, 32'd5, 32'd5, 1'b0, 1'b0, 1'b0, lat, od, of, osc, obusy, da, ba, sa);
        total++;
        if ({lat == 1, od} !== {1'b1, 32'd0}) begin bad++; $display("FAIL sub_dout got=%h lat=%0d exp=0 lat=1", od, lat); end
        total++;
        if (of !== 4'b0001) begin bad++; $display("FAIL sub_flags got=%b exp=0001", of); end
        total++;
        if (osc !== 1'b0) begin bad++; $display("FAIL sub_setcond got=%b exp=0", osc); end
    endtask

    task automatic test_sra_toggle;
        run_op(4'd8, 32'h8000_0010, 32'd4, 1'b1, 1'b1, 1'b0, lat, od, of, osc, obusy, da, ba, sa);
        total++;
        if (lat !== 5) begin bad++; $display("FAIL sra_lat got=%0d exp=5", lat); end
        total++;
        if (od !== 32'hF800_0001) begin bad++; $display("FAIL sra_dout got=%h exp=f8000001", od); end
        total++;
        if (of !== 4'b0010) begin bad++; $display("FAIL sra_flags got=%b exp=0010", of); end
        total++;
        if ({obusy, osc, ba} !== 3'b110) begin bad++; $display("FAIL sra_busy got=%b exp=110", {obusy, osc, ba}); end
    endtask

    task automatic test_sll;
        run_op(4'd6, 32'hC000_0000, 32'd1, 1'b0, 1'b0, 1'b0, lat, od, of, osc, obusy, da, ba, sa);
        total++;
        if ({lat == 2, od, of[2]} !== {1'b1, 32'h8000_0000, 1'b1}) begin
            bad++; $display("FAIL sll1 got=%h c=%b lat=%0d exp=80000000 c=1 lat=2", od, of[2], lat);
        end
        run_op(4'd6, 32'hC000_0000, 32'd0, 1'b0, 1'b0, 1'b0, lat, od, of, osc, obusy, da, ba, sa);
        total++;
        if ({lat == 1, od, of[2]} !== {1'b1, 32'hC000_0000, 1'b0}) begin
            bad++; $display("FAIL sll0 got=%h c=%b lat=%0d exp=c0000000 c=0 lat=1", od, of[2], lat);
        end
    endtask

    task automatic test_reserved;
        run_op(4'hF, $urandom, $urandom, 1'b1, 1'b0, 1'b0, lat, od, of, osc, obusy, da, ba, sa);
        total++;
        if ({lat == 1, od, of} !== {1'b1, 32'd0, 4'b0001}) begin
            bad++; $display("FAIL reserved got=%h f=%b lat=%0d exp=0 f=0001 lat=1", od, of, lat);
        end
    endtask

    task automatic test_reset_mid_shift;
        int seen;
        sel = 4'd7;
        a = 32'hFFFF_FFFF;
        b = 32'd31;
        setcc = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, sc, dout, ov, cy, ng, zr} !== 39'd0) begin
            bad++; $display("FAIL rst_mid got=%b_%h exp=0", {busy, done, sc}, dout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL rst_abort got=%0d exp=0", seen); end
        er = $urandom;
        run_op(4'd0, er, 32'd3, 1'b0, 1'b0, 1'b0, lat, od, of, osc, obusy, da, ba, sa);
        model(4'd0, er, 32'd3, er, ef);
        total++;
        if ({lat == 1, od, of} !== {1'b1, er, ef}) begin
            bad++; $display("FAIL rst_resume got=%h f=%b lat=%0d exp=%h f=%b", od, of, lat, er, ef);
        end
    endtask

    task automatic test_back_to_back;
        run_op(4'd4, 32'hA5A5_A5A5, 32'hFFFF_0000, 1'b1, 1'b0, 1'b1, lat, od, of, osc, obusy, da, ba, sa);
        total++;
        if ({da, ba} !== 2'b00) begin bad++; $display("FAIL b2b_ignore got=%b exp=00", {da, ba}); end
        run_op(4'd5, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0, lat, od, of, osc, obusy, da, ba, sa);
        total++;
        if ({lat == 1, od, of} !== {1'b1, 32'hFFFF_0000, 4'b0010}) begin
            bad++; $display("FAIL b2b_second got=%h f=%b lat=%0d exp=ffff0000 f=0010 lat=1", od, of, lat);
        end
    endtask

    task automatic test_random;
        logic [3:0]  op;
        logic [31:0] ra, rb;
        logic        rs;
        int          el;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 0) rb = ra;
            if (i % 5 == 0) ra = 32'h8000_0000;
            rs = 1'($urandom_range(0, 1));
            model(op, ra, rb, er, ef);
            el = exp_lat(op, rb);
            run_op(op, ra, rb, rs, 1'b1, 1'b0, lat, od, of, osc, obusy, da, ba, sa);
            total++;
            if (lat !== el) begin bad++; $display("FAIL rnd_lat op=%h got=%0d exp=%0d", op, lat, el); end
            total++;
            if (od !== er) begin bad++; $display("FAIL rnd_dout op=%h got=%h exp=%h", op, od, er); end
            total++;
            if (of !== ef) begin bad++; $display("FAIL rnd_flags op=%h got=%b exp=%b", op, of, ef); end
            total++;
            if ({osc, da} !== {rs, 1'b0}) begin bad++; $display("FAIL rnd_setcond got=%b exp=%b", {osc, da}, {rs, 1'b0}); end
        end
    endtask

    initial begin
        test_reset;
        test_add_ovf;
        test_sub_zero;
        test_sra_toggle;
        test_sll;
        test_reserved;
        test_reset_mid_shift;
        test_back_to_back;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cc_iterative_alu.md
Name: cc_iterative_alu

Overview:
- Multi-cycle ALU stage directly upstream of the processor status register.
- Executes one operation per START and returns a registered result plus overflow/carry/negative/zero flags.
- Emits a one-cycle Set_Conditions strobe that the PSR uses to latch {V,C,N,Z}.
- Add/sub/logic operations complete in one cycle. Shifts iterate one bit position per clock.

Parameters:
- DATAWIDTH_BUS, 32, operand and result width.
- DATAWIDTH_ALU_SELECTION, 4, opcode width.
- DATAWIDTH_SHAMT, 5, shift-amount width; equals log2(DATAWIDTH_BUS).

Ports:
- CC_ALU_CLOCK_50  in  1  system clock, rising edge.
- CC_ALU_RESET_InLow  in  1  asynchronous, active-low reset.
- CC_ALU_START  in  1  operation request; sampled only in IDLE.
- CC_ALU_SELECTION  in  DATAWIDTH_ALU_SELECTION  opcode.
- CC_ALU_SETCC  in  1  operation updates condition codes.
- CC_ALU_DATA_A  in  DATAWIDTH_BUS  operand A.
- CC_ALU_DATA_B  in  DATAWIDTH_BUS  operand B; B[DATAWIDTH_SHAMT-1:0] is the shift amount.
- CC_ALU_DATA_OUT  out  DATAWIDTH_BUS  registered result.
- CC_ALU_BUSY  out  1  high while an operation is in flight.
- CC_ALU_DONE  out  1  one-cycle pulse; result and flags valid.
- CC_ALU_Set_Conditions  out  1  one-cycle pulse coincident with DONE when SETCC was captured; drives the PSR Set_Conditions_C input.
- CC_ALU_overflow, CC_ALU_carry, CC_ALU_negative, CC_ALU_zero  out  1 each  registered flags.

Behaviour:
- Reset: asynchronous, active-low. Forces state IDLE and clears all outputs and internal operand registers to 0. Reset during SHIFT aborts the operation; no DONE is produced.
- Opcodes:
  - 0000 ADD, 0001 SUB (A-B), 0010 AND, 0011 OR, 0100 XOR, 0101 ANDN (A&~B), 0110 SLL, 0111 SRL, 1000 SRA, 1001 PASSA.
  - 1010-1111 are reserved: result 0, Z=1, V=C=N=0.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: when START=1 at an edge, capture A, B, SELECTION, SETCC. Input changes after capture are ignored.
    - Non-shift op, or shift with amount 0: compute the result, go to DONE.
    - Shift with amount n>0: load the counter with n, go to SHIFT.
  - SHIFT: shift the working register one position per clock and decrement the counter. When the counter reaches 0, register the result and flags, go to DONE.
  - DONE: lasts exactly one cycle. DONE=1; Set_Conditions=SETCC_captured. Returns to IDLE.
- Latency, measured from the START edge:
  - Non-shift ops: DONE asserts in the following cycle (latency 1).
  - Shifts: latency 1+n.
- BUSY is high in SHIFT and DONE. START is ignored while BUSY=1, including the DONE cycle, so the minimum issue interval is 2 cycles.
- Flags are computed on the full-width result:
  - N = result[MSB]; Z = (result == 0).
  - ADD: C = carry out; V = (A[MSB]==B[MSB]) && (result[MSB]!=A[MSB]).
  - SUB: C = borrow (A<B unsigned); V = (A[MSB]!=B[MSB]) && (result[MSB]!=A[MSB]).
  - Logic ops and PASSA: V=C=0.
  - Shifts: C = last bit shifted out (0 when n=0); V=0. SRA replicates the sign bit on every step.
- DATA_OUT and flags are held from DONE until the next DONE; they are updated regardless of SETCC.

Decomposition:
- Package cc_alu_pkg holds:
  - the opcode localparams: OP_ADD … OP_PASSA;
  - the state encoding (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10);
  - the width constants shared with the PSR and register file.
- Sub-module cc_alu_flag_gen: purely combinational. Takes opcode, A, B, raw result, carry-in/shift-out bit. Produces V, C, N, Z.
- The FSM, shift datapath and output registers stay in cc_iterative_alu.

Test Plan:
- Reset with RESET_InLow=0 mid-run → all outputs 0, BUSY=0; after release, the first START behaves normally.
- ADD A=0x7FFFFFFF, B=0x00000001, SETCC=1 → next cycle: DATA_OUT=0x80000000, V=1, C=0, N=1, Z=0; DONE and Set_Conditions pulse for exactly 1 cycle.
- SUB A=5, B=5, SETCC=0 → DATA_OUT=0, Z=1, C=0, V=0; DONE=1, Set_Conditions=0.
- SRA A=0x80000010, B=4 → BUSY for 5 cycles, DONE at START+5, DATA_OUT=0xF8000001, C=0, N=1. Toggling A/B/START during BUSY has no effect.
- SLL A=0xC0000000, B=1 → DATA_OUT=0x80000000, C=1, DONE at START+2. Repeat with B=0 → DATA_OUT=A, C=0, DONE at START+1.
- Reserved opcode 1111 → DATA_OUT=0, Z=1. Assert reset during an SRL by 31 at cycle 10 → no DONE is ever produced and state returns to IDLE.
